// File: rtl/uart_frame_pkg.sv
// Shared constants, FSM encoding and CRC-16/CCITT-FALSE helper for the UART frame transmitter.
package uart_frame_pkg;

    localparam logic [15:0] CRC_POLY             = 16'h1021;
    localparam logic [15:0] CRC_INIT             = 16'hFFFF;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 139;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_BYTE  = 2'd2,
        ST_TRAIL = 2'd3
    } frame_state_e;

    // One byte of MSB-first CRC-16, no reflection.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
module uart_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx_serial,
    output logic       active,
    output logic       byte_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] clk_q, clk_d;
    logic          active_q, active_d;
    logic          bit_end;

    assign bit_end   = active_q && (clk_q == CLK_LAST);
    assign byte_done = bit_end && (bit_q == 4'd9);
    assign active    = active_q;
    assign tx_serial = active_q ? shift_q[0] : 1'b1;

    // A load in the last stop-bit cycle restarts immediately, giving back-to-back bytes.
    always_comb begin
        shift_d  = shift_q;
        bit_d    = bit_q;
        clk_d    = clk_q;
        active_d = active_q;
        if (load) begin
            shift_d  = {1'b1, data, 1'b0};
            bit_d    = '0;
            clk_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (bit_end) begin
                clk_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                clk_d = clk_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '1;
            bit_q    <= '0;
            clk_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            clk_q    <= clk_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: guard lead-in, payload bytes, CRC-16 trailer, guard tail, frame_n envelope.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PAYLOAD_BYTES = 16,
    parameter int unsigned GUARD_BITS    = 2
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       tx_serial,
    output logic                       frame_n,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned GUARD_TICKS = GUARD_BITS * CLKS_PER_BIT;
    localparam int unsigned GW          = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;
    localparam int unsigned TOTAL_BYTES = PAYLOAD_BYTES + 2;
    localparam int unsigned IDX_W       = $clog2(TOTAL_BYTES + 1);

    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(TOTAL_BYTES);
    localparam logic [IDX_W-1:0] IDX_CRC_HI = IDX_W'(PAYLOAD_BYTES);
    localparam logic [IDX_W-1:0] IDX_CRC_LO = IDX_W'(PAYLOAD_BYTES + 1);

    frame_state_e                 state_q, state_d;
    logic [GW-1:0]                guard_q, guard_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [15:0]                  crc_q, crc_d;
    logic [8*PAYLOAD_BYTES-1:0]   payload_q, payload_d;
    logic                         frame_n_q, busy_q, done_q;

    logic                         accept;
    logic                         guard_last;
    logic                         all_sent;
    logic                         load;
    logic                         done_d;
    logic [7:0]                   byte_data;
    logic                         byte_tx;
    logic                         byte_active;
    logic                         byte_done;

    assign accept     = (state_q == ST_IDLE) && start;
    assign guard_last = (guard_q == GUARD_LAST);
    assign all_sent   = (idx_q == IDX_END);

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                  state_d = ST_LEAD;
            ST_LEAD:  if (guard_last)             state_d = ST_BYTE;
            ST_BYTE:  if (byte_done && all_sent)  state_d = ST_TRAIL;
            ST_TRAIL: if (guard_last)             state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        load   = 1'b0;
        done_d = 1'b0;
        case (state_q)
            ST_LEAD:  load   = guard_last;
            ST_BYTE:  load   = byte_done && !all_sent;
            ST_TRAIL: done_d = guard_last;
            default: ;
        endcase
    end

    always_comb begin
        byte_data = '0;
        for (int unsigned j = 0; j < PAYLOAD_BYTES; j++) begin
            if (idx_q == IDX_W'(j)) begin
                byte_data = payload_q[8*j +: 8];
            end
        end
        if (idx_q == IDX_CRC_HI) byte_data = crc_q[15:8];
        if (idx_q == IDX_CRC_LO) byte_data = crc_q[7:0];
    end

    // CRC advances as each payload byte enters the serializer, so it is final before the trailer loads.
    always_comb begin
        guard_d   = '0;
        idx_d     = idx_q;
        crc_d     = crc_q;
        payload_d = payload_q;
        if (((state_q == ST_LEAD) || (state_q == ST_TRAIL)) && (state_d == state_q)) begin
            guard_d = guard_q + GW'(1);
        end
        if (accept) begin
            idx_d     = '0;
            crc_d     = CRC_INIT;
            payload_d = payload;
        end else if (load) begin
            idx_d = idx_q + IDX_W'(1);
            if (idx_q < IDX_CRC_HI) begin
                crc_d = crc16_update(crc_q, byte_data);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            guard_q   <= '0;
            idx_q     <= '0;
            crc_q     <= CRC_INIT;
            payload_q <= '0;
            frame_n_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            guard_q   <= guard_d;
            idx_q     <= idx_d;
            crc_q     <= crc_d;
            payload_q <= payload_d;
            frame_n_q <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .load     (load),
        .data     (byte_data),
        .tx_serial(byte_tx),
        .active   (byte_active),
        .byte_done(byte_done)
    );

    assign tx_serial = byte_active ? byte_tx : 1'b1;
    assign frame_n   = frame_n_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomized self-checking bench for uart_frame_tx against an arithmetic line-waveform and CRC model.
module tb_uart_frame_tx;

    localparam int CPB       = 16;
    localparam int PB        = 9;
    localparam int GB        = 2;
    localparam int PW        = 8 * PB;
    localparam int GC        = GB * CPB;
    localparam int BYTE_T    = 10 * CPB;
    localparam int FRAME_LEN = (2 * GB + 10 * (PB + 2)) * CPB;
    localparam int LIMIT     = FRAME_LEN + 64;

    logic          CLK;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] payload;
    logic          tx_serial;
    logic          frame_n;
    logic          busy;
    logic          done;

    int            vectors;
    int            miscompares;
    logic [7:0]    exp_bytes [PB+2];
    logic [7:0]    obs_bytes [PB+2];
    logic          txbuf [LIMIT];
    logic [PW-1:0] next_pl;

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .PAYLOAD_BYTES(PB),
        .GUARD_BITS   (GB)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .start    (start),
        .payload  (payload),
        .tx_serial(tx_serial),
        .frame_n  (frame_n),
        .busy     (busy),
        .done     (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit-serial LFSR form of CRC-16/CCITT-FALSE over the payload stream.
    function automatic logic [15:0] ref_crc(input logic [PW-1:0] pl);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int j = 0; j < PB; j++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ pl[8*j + k];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] v;
        for (int j = 0; j < PB; j++) v[8*j +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic build_expected(input logic [PW-1:0] pl);
        logic [15:0] c;
        c = ref_crc(pl);
        for (int j = 0; j < PB; j++) exp_bytes[j] = pl[8*j +: 8];
        exp_bytes[PB]     = c[15:8];
        exp_bytes[PB + 1] = c[7:0];
    endtask

    // Expected line level t cycles after frame_n fell.
    function automatic logic exp_tx(input int t);
        int k, b, bt;
        if (t < GC) return 1'b1;
        k = t - GC;
        if (k >= BYTE_T * (PB + 2)) return 1'b1;
        b  = k / BYTE_T;
        bt = (k % BYTE_T) / CPB;
        if (bt == 0) return 1'b0;
        if (bt == 9) return 1'b1;
        return exp_bytes[b][bt - 1];
    endfunction

    // Entered on the first negedge with frame_n low; returns on the first negedge with it high.
    task automatic capture(input int mode);
        int t, wave_err, busy_err, early_done, first_low;
        logic [9:0] obs;
        for (int i = 0; i < LIMIT; i++) txbuf[i] = 1'bx;
        t = 0; wave_err = 0; busy_err = 0; early_done = 0;
        while (frame_n === 1'b0 && t < LIMIT) begin
            txbuf[t] = tx_serial;
            if (tx_serial !== exp_tx(t)) wave_err++;
            if (busy !== 1'b1) busy_err++;
            if (done !== 1'b0) early_done++;
            if (mode == 1 && t == FRAME_LEN / 2) begin
                start   = 1'b1;
                payload = rand_payload();
            end
            if (mode == 1 && t == FRAME_LEN / 2 + 1) start = 1'b0;
            @(negedge CLK);
            t++;
        end
        check_eq("frame_len", t, FRAME_LEN);
        check_eq("tx_wave_err", wave_err, 0);
        check_eq("busy_env_err", busy_err, 0);
        check_eq("done_early", early_done, 0);
        check_eq("done_at_end", {31'd0, done}, 1);
        check_eq("busy_at_end", {31'd0, busy}, 0);
        first_low = -1;
        for (int i = 0; i < t && i < LIMIT; i++) begin
            if (txbuf[i] === 1'b0 && first_low < 0) first_low = i;
        end
        check_eq("lead_len", first_low, GC);
        for (int b = 0; b < PB + 2; b++) begin
            for (int i = 0; i < 10; i++) obs[i] = txbuf[GC + b * BYTE_T + i * CPB + CPB / 2];
            obs_bytes[b] = obs[8:1];
            check_eq($sformatf("byte%0d", b), {22'd0, obs}, {22'd0, 1'b1, exp_bytes[b], 1'b0});
        end
    endtask

    // mode 0: single pulse, 1: extra start mid-frame, 2: start held with payload switched to next_pl.
    task automatic send_frame(input logic [PW-1:0] pl, input int mode);
        int lat;
        payload = pl;
        start   = 1'b1;
        build_expected(pl);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (frame_n !== 1'b0 && lat < 4);
        check_eq("accept_lat", lat, 1);
        if (mode == 2) payload = next_pl;
        else start = 1'b0;
        capture(mode);
    endtask

    task automatic check_done_width();
        @(negedge CLK);
        check_eq("done_width", {31'd0, done}, 0);
    endtask

    initial begin
        logic [PW-1:0] pl;
        int            idle_bad;

        vectors = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        payload = '0;
        #22;
        check_eq("reset_state", {28'd0, tx_serial, frame_n, busy, done}, 32'b1100);

        // Release reset and request in the same cycle: first edge out of reset must accept.
        @(negedge CLK);
        rst_n = 1'b1;
        send_frame(72'h39_38_37_36_35_34_33_32_31, 0);
        check_eq("known_crc_hi", {24'd0, obs_bytes[PB]}, 32'h29);
        check_eq("known_crc_lo", {24'd0, obs_bytes[PB + 1]}, 32'hB1);
        check_done_width();

        for (int n = 0; n < 3; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            send_frame(rand_payload(), 0);
            check_done_width();
        end

        send_frame(rand_payload(), 1);
        check_done_width();
        idle_bad = 0;
        repeat (5) begin
            @(negedge CLK);
            if (frame_n !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check_eq("no_queue", idle_bad, 0);

        next_pl = rand_payload();
        send_frame(rand_payload(), 2);
        build_expected(next_pl);
        @(negedge CLK);
        check_eq("b2b_gap", {31'd0, frame_n}, 0);
        start = 1'b0;
        capture(0);
        check_done_width();

        pl = rand_payload();
        pl[8*5 +: 8] = 8'h00;
        payload = pl;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (GC + 5 * BYTE_T + 3 * CPB + CPB / 2) @(negedge CLK);
        check_eq("pre_rst", {30'd0, tx_serial, frame_n}, 0);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async", {28'd0, tx_serial, frame_n, busy, done}, 32'b1100);
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (40) begin
            @(negedge CLK);
            if (done !== 1'b0 || frame_n !== 1'b1 || tx_serial !== 1'b1) idle_bad++;
        end
        check_eq("no_resume", idle_bad, 0);

        send_frame(rand_payload(), 0);
        check_done_width();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
